gamma_cycle_ctrl: RTL and testbench

Sequencer for the temporal (race-logic) datapath built from greater_than_eq-style operators. It divides time into gamma cycles of GAMMA_CYCLE_WIDTH aclk periods. Each gamma cycle has a reset phase that drives the operators' local latch reset, then a compute phase with an input-launch window sized so every PULSE_WIDTH output pulse finishes before the next reset. It runs a programmed number of gamma cycles, or runs free until stopped, and emits phase strobes for input encoders and output samplers.

---
 rtl/gamma_cycle_ctrl.sv | 139 +++++++++++++
 tb/tb_gamma_cycle_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gamma_cycle_ctrl.sv
// Gamma-cycle sequencer for a race-logic datapath: per cycle a local reset phase,
// then a compute phase with an input-launch window that lets every output pulse finish.
module gamma_cycle_ctrl #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int RESET_CYCLES      = 2,
  parameter int PULSE_WIDTH       = 8,
  parameter int NUM_CYCLES_WIDTH  = 8
) (
  input  logic                                  aclk,
  input  logic                                  grst_n,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic [NUM_CYCLES_WIDTH-1:0]           num_cycles,
  output logic                                  busy,
  output logic                                  lrst,
  output logic                                  in_en,
  output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0]  t_count,
  output logic                                  gamma_start,
  output logic                                  gamma_done,
  output logic [NUM_CYCLES_WIDTH-1:0]           cycle_idx,
  output logic                                  done
);

  localparam int C  = GAMMA_CYCLE_WIDTH - RESET_CYCLES;
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [TW-1:0] T_LAST   = TW'(C - 1);
  localparam logic [TW-1:0] T_IN_END = TW'(C - PULSE_WIDTH);
  localparam logic [RW-1:0] R_LAST   = RW'(RESET_CYCLES - 1);

  generate
    if (RESET_CYCLES < 1 || C <= PULSE_WIDTH) begin : g_illegal
      $error("gamma_cycle_ctrl: need RESET_CYCLES >= 1 and compute length > PULSE_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t                      state;
  logic [RW-1:0]               rst_cnt;
  logic [NUM_CYCLES_WIDTH-1:0] num_lat;
  logic                        stop_pending;
  logic [TW-1:0]               t_next;
  logic                        finished;

  assign t_next = t_count + 1'b1;

  // A zero count means free-run: only a stop request can end the run.
  assign finished = stop_pending | stop |
                    ((num_lat != '0) && (cycle_idx == num_lat - 1'b1));

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      state        <= S_IDLE;
      rst_cnt      <= '0;
      num_lat      <= '0;
      stop_pending <= 1'b0;
      busy         <= 1'b0;
      lrst         <= 1'b1;
      in_en        <= 1'b0;
      t_count      <= '0;
      gamma_start  <= 1'b0;
      gamma_done   <= 1'b0;
      cycle_idx    <= '0;
      done         <= 1'b0;
    end else begin
      gamma_start <= 1'b0;
      gamma_done  <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          busy    <= 1'b0;
          lrst    <= 1'b1;
          in_en   <= 1'b0;
          t_count <= '0;
          if (start) begin
            num_lat      <= num_cycles;
            cycle_idx    <= '0;
            stop_pending <= 1'b0;
            rst_cnt      <= '0;
            busy         <= 1'b1;
            state        <= S_RESET;
          end
        end

        S_RESET: begin
          if (stop) stop_pending <= 1'b1;
          if (rst_cnt == R_LAST) begin
            state       <= S_COMPUTE;
            lrst        <= 1'b0;
            t_count     <= '0;
            gamma_start <= 1'b1;
            in_en       <= ('0 < T_IN_END);
            gamma_done  <= (T_LAST == '0);
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        S_COMPUTE: begin
          if (stop) stop_pending <= 1'b1;
          if (t_count == T_LAST) begin
            // The gamma cycle has fully completed; decide between another cycle and the end.
            in_en   <= 1'b0;
            t_count <= '0;
            lrst    <= 1'b1;
            if (finished) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              cycle_idx <= cycle_idx + 1'b1;
              rst_cnt   <= '0;
              state     <= S_RESET;
            end
          end else begin
            t_count    <= t_next;
            in_en      <= (t_next < T_IN_END);
            gamma_done <= (t_next == T_LAST);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          lrst  <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_cycle_ctrl.sv
// Directed bench for gamma_cycle_ctrl: per-cycle phase timing, counted runs,
// graceful stop, ignored restarts, mid-run reset and index wrap on a narrow instance.
module tb_gamma_cycle_ctrl;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic       grst_n, start, stop;
  logic [7:0] num_cycles;
  logic       busy, lrst, in_en, gamma_start, gamma_done, done;
  logic [3:0] t_count;
  logic [7:0] cycle_idx;

  logic       start2, stop2;
  logic [1:0] num2;
  logic       busy2, lrst2, in_en2, gs2, gd2, done2;
  logic [3:0] t_count2;
  logic [1:0] idx2;

  gamma_cycle_ctrl #(.GAMMA_CYCLE_WIDTH(16), .RESET_CYCLES(2), .PULSE_WIDTH(8), .NUM_CYCLES_WIDTH(8)) dut (
    .aclk(aclk), .grst_n(grst_n), .start(start), .stop(stop), .num_cycles(num_cycles),
    .busy(busy), .lrst(lrst), .in_en(in_en), .t_count(t_count), .gamma_start(gamma_start),
    .gamma_done(gamma_done), .cycle_idx(cycle_idx), .done(done)
  );

  gamma_cycle_ctrl #(.GAMMA_CYCLE_WIDTH(16), .RESET_CYCLES(2), .PULSE_WIDTH(8), .NUM_CYCLES_WIDTH(2)) dut2 (
    .aclk(aclk), .grst_n(grst_n), .start(start2), .stop(stop2), .num_cycles(num2),
    .busy(busy2), .lrst(lrst2), .in_en(in_en2), .t_count(t_count2), .gamma_start(gs2),
    .gamma_done(gd2), .cycle_idx(idx2), .done(done2)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int gs_idx[$];
  int gs_time[$];
  int gd_count, done_count, gs_after_done, done_time, last_gd_time;
  bit timed_out;

  task automatic pulse_start(input logic [7:0] n, input logic with_stop);
    @(negedge aclk);
    num_cycles = n;
    start = 1'b1;
    stop  = with_stop;
    @(negedge aclk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Watches a run already started; optionally injects stop/start at a given (idx, t).
  task automatic collect(input int max_cyc, input int stop_idx, input int stop_t,
                         input int re_idx, input int re_t);
    int tail;
    tail = -1;
    gs_idx.delete(); gs_time.delete();
    gd_count = 0; done_count = 0; gs_after_done = 0; done_time = -1; last_gd_time = -1;
    for (int i = 0; i < max_cyc; i++) begin
      if (gamma_start) begin
        gs_idx.push_back(int'(cycle_idx));
        gs_time.push_back(cyc);
        if (done_count > 0) gs_after_done++;
        $display("  gamma cycle idx=%0d starts at cycle %0d", cycle_idx, cyc);
      end
      if (gamma_done) begin gd_count++; last_gd_time = cyc; end
      if (done) begin done_count++; done_time = cyc; end
      stop  = (!lrst && int'(cycle_idx) == stop_idx && int'(t_count) == stop_t);
      start = (!lrst && int'(cycle_idx) == re_idx && int'(t_count) == re_t);
      if (done && tail < 0) tail = 20;
      else if (tail > 0) tail--;
      if (tail == 0) break;
      @(negedge aclk);
    end
    stop = 1'b0;
    start = 1'b0;
    timed_out = (done_count == 0);
  endtask

  task automatic test_reset;
    grst_n = 1'b0;
    repeat (3) @(negedge aclk);
    checks++; if (lrst !== 1'b1) begin errors++; $display("FAIL reset_lrst: got %b want 1", lrst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_en !== 1'b0) begin errors++; $display("FAIL reset_in_en: got %b want 0", in_en); end
    checks++; if (t_count !== 4'd0) begin errors++; $display("FAIL reset_t_count: got %0d want 0", t_count); end
    checks++; if ({gamma_start, gamma_done, done} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {gamma_start, gamma_done, done}); end
    checks++; if (cycle_idx !== 8'd0) begin errors++; $display("FAIL reset_cycle_idx: got %0d want 0", cycle_idx); end
    grst_n = 1'b1;
    @(negedge aclk);
    checks++; if ({busy, lrst} !== 2'b01) begin errors++; $display("FAIL idle_after_reset: busy,lrst got %b want 01", {busy, lrst}); end
    $display("test_reset done");
  endtask

  task automatic test_single;
    logic [9:0] got, exp;
    pulse_start(8'd1, 1'b0);
    // vector: busy lrst in_en gamma_start gamma_done done t_count[3:0]
    for (int r = 0; r < 2; r++) begin
      got = {busy, lrst, in_en, gamma_start, gamma_done, done, t_count};
      exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      checks++; if (got !== exp) begin errors++; $display("FAIL single_reset_phase%0d: got %b want %b", r, got, exp); end
      @(negedge aclk);
    end
    for (int i = 0; i < 14; i++) begin
      got = {busy, lrst, in_en, gamma_start, gamma_done, done, t_count};
      exp = {1'b1, 1'b0, (i < 6), (i == 0), (i == 13), 1'b0, 4'(i)};
      checks++; if (got !== exp) begin errors++; $display("FAIL single_compute_t%0d: got %b want %b", i, got, exp); end
      @(negedge aclk);
    end
    got = {busy, lrst, in_en, gamma_start, gamma_done, done, t_count};
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL single_done: got %b want %b", got, exp); end
    @(negedge aclk);
    got = {busy, lrst, in_en, gamma_start, gamma_done, done, t_count};
    exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL single_idle: got %b want %b", got, exp); end
    $display("test_single done");
  endtask

  task automatic test_multi;
    pulse_start(8'd3, 1'b0);
    collect(200, -1, -1, -1, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL multi_timeout: no done within bound"); end
    checks++; if (gd_count !== 3) begin errors++; $display("FAIL multi_gamma_done: got %0d want 3", gd_count); end
    checks++; if (done_count !== 1) begin errors++; $display("FAIL multi_done: got %0d want 1", done_count); end
    checks++; if (gs_idx.size() !== 3) begin errors++; $display("FAIL multi_gs_count: got %0d want 3", gs_idx.size()); end
    for (int i = 0; i < gs_idx.size() && i < 3; i++) begin
      checks++; if (gs_idx[i] !== i) begin errors++; $display("FAIL multi_idx%0d: got %0d want %0d", i, gs_idx[i], i); end
      if (i > 0) begin
        checks++; if (gs_time[i] - gs_time[i-1] !== 16) begin errors++; $display("FAIL multi_period%0d: got %0d want 16", i, gs_time[i] - gs_time[i-1]); end
      end
    end
    checks++; if (done_time !== last_gd_time + 1) begin errors++; $display("FAIL multi_done_timing: got %0d want %0d", done_time, last_gd_time + 1); end
    $display("test_multi done");
  endtask

  task automatic test_stop;
    pulse_start(8'd0, 1'b0);
    collect(400, 5, 4, -1, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL stop_timeout: no done within bound"); end
    checks++; if (gd_count !== 6) begin errors++; $display("FAIL stop_gamma_done: got %0d want 6", gd_count); end
    checks++; if (gs_idx.size() !== 6) begin errors++; $display("FAIL stop_gs_count: got %0d want 6", gs_idx.size()); end
    checks++; if (done_time !== last_gd_time + 1) begin errors++; $display("FAIL stop_done_timing: got %0d want %0d", done_time, last_gd_time + 1); end
    checks++; if (gs_after_done !== 0) begin errors++; $display("FAIL stop_after_done: got %0d want 0", gs_after_done); end
    $display("test_stop done");
  endtask

  task automatic test_back_to_back;
    pulse_start(8'd3, 1'b0);
    collect(200, -1, -1, 1, 3);
    checks++; if (gd_count !== 3) begin errors++; $display("FAIL restart_gamma_done: got %0d want 3", gd_count); end
    checks++; if (gs_idx.size() !== 3) begin errors++; $display("FAIL restart_gs_count: got %0d want 3", gs_idx.size()); end
    for (int i = 0; i < gs_idx.size() && i < 3; i++) begin
      checks++; if (gs_idx[i] !== i) begin errors++; $display("FAIL restart_idx%0d: got %0d want %0d", i, gs_idx[i], i); end
    end
    pulse_start(8'd2, 1'b1);
    collect(200, -1, -1, -1, -1);
    checks++; if (gd_count !== 2) begin errors++; $display("FAIL startstop_gamma_done: got %0d want 2", gd_count); end
    checks++; if (done_count !== 1) begin errors++; $display("FAIL startstop_done: got %0d want 1", done_count); end
    $display("test_back_to_back done");
  endtask

  task automatic test_midreset;
    bit hit;
    hit = 1'b0;
    pulse_start(8'd0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (!lrst && t_count == 4'd7) begin hit = 1'b1; break; end
      @(negedge aclk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL midreset_reach_t7: t_count=7 not reached"); end
    grst_n = 1'b0;
    #1;
    checks++; if ({lrst, busy, in_en, done} !== 4'b1000) begin errors++; $display("FAIL midreset_outputs: lrst,busy,in_en,done got %b want 1000", {lrst, busy, in_en, done}); end
    checks++; if (t_count !== 4'd0) begin errors++; $display("FAIL midreset_t_count: got %0d want 0", t_count); end
    @(negedge aclk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_no_done: got %b want 0", done); end
    grst_n = 1'b1;
    pulse_start(8'd1, 1'b0);
    collect(100, -1, -1, -1, -1);
    checks++; if (gd_count !== 1 || done_count !== 1) begin errors++; $display("FAIL midreset_rerun: gamma_done=%0d done=%0d want 1 1", gd_count, done_count); end
    checks++; if (gs_idx.size() < 1 || gs_idx[0] !== 0) begin errors++; $display("FAIL midreset_rerun_idx: first idx not 0 (count %0d)", gs_idx.size()); end
    $display("test_midreset done");
  endtask

  task automatic test_wrap;
    int seen[$];
    int exp_w[6];
    bit got_done;
    exp_w = '{0, 1, 2, 3, 0, 1};
    got_done = 1'b0;
    @(negedge aclk);
    num2 = 2'd0; start2 = 1'b1;
    @(negedge aclk);
    start2 = 1'b0;
    for (int i = 0; i < 200 && seen.size() < 6; i++) begin
      if (gs2) seen.push_back(int'(idx2));
      @(negedge aclk);
    end
    stop2 = 1'b1;
    @(negedge aclk);
    stop2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done2) begin got_done = 1'b1; break; end
      @(negedge aclk);
    end
    checks++; if (seen.size() !== 6) begin errors++; $display("FAIL wrap_count: got %0d want 6", seen.size()); end
    for (int i = 0; i < seen.size() && i < 6; i++) begin
      checks++; if (seen[i] !== exp_w[i]) begin errors++; $display("FAIL wrap_idx%0d: got %0d want %0d", i, seen[i], exp_w[i]); end
    end
    checks++; if (!got_done) begin errors++; $display("FAIL wrap_done: no done after stop"); end
    $display("test_wrap done");
  endtask

  initial begin
    grst_n = 1'b0; start = 1'b0; stop = 1'b0; num_cycles = '0;
    start2 = 1'b0; stop2 = 1'b0; num2 = '0;
    test_reset();
    test_single();
    test_multi();
    test_stop();
    test_back_to_back();
    test_midreset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
